commit_trace_fifo: RTL and testbench
====================================

Name: commit_trace_fifo

Overview:
Parametrised commit-trace capture buffer between the core's retire port(s) and a trace consumer (log writer, debug bridge, or scoreboard). Each cycle it accepts up to NCHAN retired-instruction records (pc, instr, rd write, mem write). It tags each record with a sequence number and queues it in a circular buffer. Records drain one per cycle over a valid/ready stream, and overflow is handled by backpressure or counted drops.

Parameters:
XLEN, riscv_pkg::XLEN, data/address width
NCHAN, 1, retire lanes per cycle (1..4)
DEPTH, 16, buffer entries; power of two, >= 2*NCHAN
DROP_ON_FULL, 0, 1 = drop and count on overflow; 0 = assert stall_o and still count anything that overflows

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
update_i  in  NCHAN  lane k retired an instruction this cycle
pc_i  in  NCHAN*XLEN  per-lane pc
instr_i  in  NCHAN*32  per-lane instruction word
reg_addr_i  in  NCHAN*5  per-lane rd
reg_data_i  in  NCHAN*XLEN  per-lane rd write data
mem_wrt_i  in  NCHAN  per-lane store flag
mem_addr_i  in  NCHAN*XLEN  per-lane store address
mem_data_i  in  NCHAN*XLEN  per-lane store data
stall_o  out  1  core must not retire next cycle (unused when DROP_ON_FULL=1; tied 0)
rec_valid_o  out  1  head record available
rec_ready_i  in  1  consumer takes head record
rec_o  out  $bits(commit_rec_t)  head record
count_o  out  $clog2(DEPTH)+1  occupancy
drop_cnt_o  out  32  records lost, saturating
seq_o  out  32  next sequence number to assign

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: count=0, head/tail=0, seq=0, drop_cnt=0, rec_valid_o=0, stall_o=0. Buffer contents are don't-care. Reset wins over any simultaneous push or pop.
- Push count: n = popcount(update_i). Free space is computed from the registered count only: free = DEPTH - count. A same-cycle pop does not add space.
- Accept rule: if n <= free, all n records are written in ascending lane order at tail, tail+1, and so on, modulo DEPTH.
  - Record i gets seq+i.
  - seq advances by n.
- Overflow: if n > free, the whole cycle's group is rejected; no partial groups are written.
  - drop_cnt advances by n, saturating at 2^32-1.
  - seq advances by n anyway, so the consumer sees gaps.
- Record build: rd_we = (reg_addr != 0). When rd_we=0, rd_addr and rd_data are stored as 0. When mem_wrt=0, mem_addr and mem_data are stored as 0.
- stall_o: combinational, = (count > DEPTH-NCHAN). A core honouring it never overflows.
- Output stream: rec_valid_o = (count != 0). rec_o = entry[head], read combinationally from registered storage.
  - Pop occurs when rec_valid_o && rec_ready_i; head advances by 1 modulo DEPTH.
  - rec_o is stable while rec_valid_o=1 and rec_ready_i=0.
- Simultaneous push and pop: count_next = count + accepted_n - pop.
- Latency: a record pushed in cycle t is visible on rec_o in cycle t+1 if the buffer was empty (no fall-through).
- Pointer width: pointers are $clog2(DEPTH) bits and wrap naturally. Count is one bit wider, so full (count=DEPTH) is distinct from empty.
- Reset mid-stream: all queued records are discarded. seq restarts at 0.

Decomposition:
- riscv_pkg gets:
  - typedef commit_rec_t, a packed struct: seq[31:0], pc, instr[31:0], rd_addr[4:0], rd_data, rd_we, mem_addr, mem_data, mem_we.
  - constant TRACE_MAX_CHAN=4.
- One sub-module is natural: commit_rec_pack. It is per lane and combinational, building commit_rec_t from raw lane signals plus seq. It is instantiated NCHAN times in a generate loop.
- Storage and pointers stay in the top.

Test Plan:
1. NCHAN=1, DEPTH=4. Retire pc=0x80000000 with instr=0x00500093, rd=1, data=5, holding rec_ready_i=0 -> next cycle rec_valid_o=1, rec_o.seq=0, rd_we=1, rd_data=0x5, count_o=1.
2. NCHAN=1. Retire instr 0x00000013 (rd=0) -> rd_we=0, rd_addr=0, rd_data=0. Separately retire a store with mem_wrt=1, addr=0x80000010, data=0xDEADBEEF -> mem_we=1 with those values.
3. NCHAN=2, DEPTH=4. Both lanes update for 2 cycles with ready=0 -> count_o=4. stall_o=1 from the cycle count reaches 3. Records come out with seq 0,1,2,3 in lane order.
4. Same setup with DROP_ON_FULL=1. Push a third pair while full -> group rejected, drop_cnt_o=2, seq_o=6. After one pop, count_o=3. A 2-lane push still drops (free=1), and drop_cnt_o becomes 4.
5. DEPTH=4, NCHAN=1. Push and pop every cycle for 10 cycles -> count_o holds at 1. Pointers wrap, and seq on rec_o runs 0..9 with no gaps.
6. With count_o=3, assert rst_i together with update_i and rec_ready_i -> next cycle count_o=0, rec_valid_o=0, seq_o=0, drop_cnt_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-side types: data width and the commit-trace record layout.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int TRACE_MAX_CHAN = 4;

  typedef struct packed {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_we;
  } commit_rec_t;

endpackage

// File: rtl/commit_rec_pack.sv
// Builds one commit_rec_t from a single retire lane; unused fields are zeroed
// so that records compare cleanly downstream.
module commit_rec_pack
  import riscv_pkg::*;
(
  input  logic [31:0]     seq,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [4:0]      reg_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_wrt,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  output commit_rec_t     rec
);

  always_comb begin
    rec          = '0;
    rec.seq      = seq;
    rec.pc       = pc;
    rec.instr    = instr;
    // x0 writes are architecturally invisible, so they are not reported.
    rec.rd_we    = (reg_addr != 5'd0);
    rec.rd_addr  = rec.rd_we ? reg_addr : 5'd0;
    rec.rd_data  = rec.rd_we ? reg_data : '0;
    rec.mem_we   = mem_wrt;
    rec.mem_addr = mem_wrt ? mem_addr : '0;
    rec.mem_data = mem_wrt ? mem_data : '0;
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit-trace capture buffer: tags up to NCHAN retired records per cycle with
// a sequence number and drains them one per cycle over a valid/ready stream.
module commit_trace_fifo #(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int NCHAN        = 1,
  parameter int DEPTH        = 16,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NCHAN-1:0]          update_i,
  input  logic [NCHAN*XLEN-1:0]     pc_i,
  input  logic [NCHAN*32-1:0]       instr_i,
  input  logic [NCHAN*5-1:0]        reg_addr_i,
  input  logic [NCHAN*XLEN-1:0]     reg_data_i,
  input  logic [NCHAN-1:0]          mem_wrt_i,
  input  logic [NCHAN*XLEN-1:0]     mem_addr_i,
  input  logic [NCHAN*XLEN-1:0]     mem_data_i,
  output logic                      stall_o,
  output logic                      rec_valid_o,
  input  logic                      rec_ready_i,
  output riscv_pkg::commit_rec_t    rec_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [31:0]               drop_cnt_o,
  output logic [31:0]               seq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Stream handshake: rec_o is the head entry whenever rec_valid_o is high and
  // is held stable until a cycle where rec_valid_o && rec_ready_i pops it.

  riscv_pkg::commit_rec_t mem [DEPTH];
  riscv_pkg::commit_rec_t lane_rec [NCHAN];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   seq_q, drop_q;

  logic [CW-1:0] push_n, free_n;
  logic [31:0]   lane_seq [NCHAN];
  logic [PW-1:0] lane_idx [NCHAN];
  logic          accept, pop;
  logic [32:0]   drop_sum;

  // Prefix count of active lanes gives each record its slot and sequence offset.
  always_comb begin
    push_n = '0;
    for (int k = 0; k < NCHAN; k++) begin
      lane_seq[k] = seq_q + 32'(push_n);
      lane_idx[k] = tail_q + push_n[PW-1:0];
      if (update_i[k]) push_n = push_n + CW'(1);
    end
  end

  // Space comes from the registered count only; a same-cycle pop does not help.
  assign free_n   = CW'(DEPTH) - count_q;
  assign accept   = (push_n <= free_n);
  assign pop      = (count_q != '0) && rec_ready_i;
  assign drop_sum = {1'b0, drop_q} + 33'(push_n);

  for (genvar k = 0; k < NCHAN; k++) begin : g_lane
    commit_rec_pack u_pack (
      .seq      (lane_seq[k]),
      .pc       (pc_i[k*XLEN +: XLEN]),
      .instr    (instr_i[k*32 +: 32]),
      .reg_addr (reg_addr_i[k*5 +: 5]),
      .reg_data (reg_data_i[k*XLEN +: XLEN]),
      .mem_wrt  (mem_wrt_i[k]),
      .mem_addr (mem_addr_i[k*XLEN +: XLEN]),
      .mem_data (mem_data_i[k*XLEN +: XLEN]),
      .rec      (lane_rec[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      for (int k = 0; k < NCHAN; k++) begin
        if (update_i[k]) mem[lane_idx[k]] <= lane_rec[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      head_q <= head_q + PW'(pop);
      seq_q  <= seq_q + 32'(push_n);
      if (accept) begin
        tail_q  <= tail_q + push_n[PW-1:0];
        count_q <= count_q + push_n - CW'(pop);
      end else begin
        count_q <= count_q - CW'(pop);
        drop_q  <= drop_sum[32] ? '1 : drop_sum[31:0];
      end
    end
  end

  assign stall_o     = !DROP_ON_FULL && (count_q > CW'(DEPTH - NCHAN));
  assign rec_valid_o = (count_q != '0);
  assign rec_o       = mem[head_q];
  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;
  assign seq_o       = seq_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo: one 1-lane instance and two 2-lane
// instances (stall mode and drop mode) sharing the 2-lane stimulus.
module tb_commit_trace_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 1-lane, DEPTH=4, stall mode
  logic [0:0]  d1_update, d1_mem_wrt;
  logic [31:0] d1_pc, d1_instr, d1_reg_data, d1_mem_addr, d1_mem_data;
  logic [4:0]  d1_reg_addr;
  logic        d1_ready, d1_stall, d1_valid;
  riscv_pkg::commit_rec_t d1_rec;
  logic [2:0]  d1_count;
  logic [31:0] d1_drop, d1_seq;

  // 2-lane, DEPTH=4: shared inputs, d2 stall mode, d3 drop mode
  logic [1:0]  w_update, w_mem_wrt;
  logic [63:0] w_pc, w_instr, w_reg_data, w_mem_addr, w_mem_data;
  logic [9:0]  w_reg_addr;
  logic        w_ready;
  logic        d2_stall, d2_valid, d3_stall, d3_valid;
  riscv_pkg::commit_rec_t d2_rec, d3_rec;
  logic [2:0]  d2_count, d3_count;
  logic [31:0] d2_drop, d2_seq, d3_drop, d3_seq;

  commit_trace_fifo #(.NCHAN(1), .DEPTH(4), .DROP_ON_FULL(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .update_i(d1_update), .pc_i(d1_pc), .instr_i(d1_instr),
    .reg_addr_i(d1_reg_addr), .reg_data_i(d1_reg_data), .mem_wrt_i(d1_mem_wrt),
    .mem_addr_i(d1_mem_addr), .mem_data_i(d1_mem_data), .stall_o(d1_stall),
    .rec_valid_o(d1_valid), .rec_ready_i(d1_ready), .rec_o(d1_rec), .count_o(d1_count),
    .drop_cnt_o(d1_drop), .seq_o(d1_seq)
  );

  commit_trace_fifo #(.NCHAN(2), .DEPTH(4), .DROP_ON_FULL(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .update_i(w_update), .pc_i(w_pc), .instr_i(w_instr),
    .reg_addr_i(w_reg_addr), .reg_data_i(w_reg_data), .mem_wrt_i(w_mem_wrt),
    .mem_addr_i(w_mem_addr), .mem_data_i(w_mem_data), .stall_o(d2_stall),
    .rec_valid_o(d2_valid), .rec_ready_i(w_ready), .rec_o(d2_rec), .count_o(d2_count),
    .drop_cnt_o(d2_drop), .seq_o(d2_seq)
  );

  commit_trace_fifo #(.NCHAN(2), .DEPTH(4), .DROP_ON_FULL(1'b1)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .update_i(w_update), .pc_i(w_pc), .instr_i(w_instr),
    .reg_addr_i(w_reg_addr), .reg_data_i(w_reg_data), .mem_wrt_i(w_mem_wrt),
    .mem_addr_i(w_mem_addr), .mem_data_i(w_mem_data), .stall_o(d3_stall),
    .rec_valid_o(d3_valid), .rec_ready_i(w_ready), .rec_o(d3_rec), .count_o(d3_count),
    .drop_cnt_o(d3_drop), .seq_o(d3_seq)
  );

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_group(input int g);
    w_update   = 2'b11;
    w_pc       = {32'h1004 + 32'(8*g), 32'h1000 + 32'(8*g)};
    w_instr    = {32'h00200113, 32'h00100093};
    w_reg_addr = {5'd2, 5'd1};
    w_reg_data = {32'h200 + 32'(g), 32'h100 + 32'(g)};
  endtask

  task automatic test_reset();
    n_checks++; if (d1_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", d1_count); end
    n_checks++; if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", d1_valid); end
    n_checks++; if (d1_seq !== 32'd0) begin n_fail++; $display("FAIL reset_seq: got %0d expected 0", d1_seq); end
    n_checks++; if (d3_drop !== 32'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", d3_drop); end
    n_checks++; if (d2_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", d2_stall); end
  endtask

  task automatic test_single();
    d1_update = 1'b1; d1_pc = 32'h80000000; d1_instr = 32'h00500093;
    d1_reg_addr = 5'd1; d1_reg_data = 32'h5; d1_mem_wrt = 1'b0; d1_ready = 1'b0;
    tick();
    d1_update = 1'b0;
    n_checks++; if (d1_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", d1_valid); end
    n_checks++; if (d1_rec.seq !== 32'd0) begin n_fail++; $display("FAIL single_seq: got %0d expected 0", d1_rec.seq); end
    n_checks++; if (d1_rec.pc !== 32'h80000000) begin n_fail++; $display("FAIL single_pc: got %h expected 80000000", d1_rec.pc); end
    n_checks++; if (d1_rec.rd_we !== 1'b1) begin n_fail++; $display("FAIL single_rd_we: got %b expected 1", d1_rec.rd_we); end
    n_checks++; if (d1_rec.rd_addr !== 5'd1) begin n_fail++; $display("FAIL single_rd_addr: got %0d expected 1", d1_rec.rd_addr); end
    n_checks++; if (d1_rec.rd_data !== 32'h5) begin n_fail++; $display("FAIL single_rd_data: got %h expected 5", d1_rec.rd_data); end
    n_checks++; if (d1_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", d1_count); end
    n_checks++; if (d1_seq !== 32'd1) begin n_fail++; $display("FAIL single_seq_o: got %0d expected 1", d1_seq); end
    tick();
    n_checks++; if (d1_rec.seq !== 32'd0) begin n_fail++; $display("FAIL single_hold: got %0d expected 0", d1_rec.seq); end
    d1_ready = 1'b1;
    tick();
    d1_ready = 1'b0;
    n_checks++; if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", d1_valid); end
  endtask

  task automatic test_record_build();
    d1_update = 1'b1; d1_instr = 32'h00000013; d1_reg_addr = 5'd0; d1_reg_data = 32'h1234;
    d1_mem_wrt = 1'b0; d1_mem_addr = 32'h55; d1_mem_data = 32'h66;
    tick();
    d1_update = 1'b0;
    n_checks++; if (d1_rec.rd_we !== 1'b0) begin n_fail++; $display("FAIL nop_rd_we: got %b expected 0", d1_rec.rd_we); end
    n_checks++; if (d1_rec.rd_data !== 32'h0) begin n_fail++; $display("FAIL nop_rd_data: got %h expected 0", d1_rec.rd_data); end
    n_checks++; if (d1_rec.mem_addr !== 32'h0) begin n_fail++; $display("FAIL nop_mem_addr: got %h expected 0", d1_rec.mem_addr); end
    n_checks++; if (d1_rec.seq !== 32'd1) begin n_fail++; $display("FAIL nop_seq: got %0d expected 1", d1_rec.seq); end
    d1_ready = 1'b1;
    tick();
    d1_ready = 1'b0;
    d1_update = 1'b1; d1_instr = 32'h00112023; d1_mem_wrt = 1'b1;
    d1_mem_addr = 32'h80000010; d1_mem_data = 32'hDEADBEEF;
    tick();
    d1_update = 1'b0; d1_mem_wrt = 1'b0;
    n_checks++; if (d1_rec.mem_we !== 1'b1) begin n_fail++; $display("FAIL st_mem_we: got %b expected 1", d1_rec.mem_we); end
    n_checks++; if (d1_rec.mem_addr !== 32'h80000010) begin n_fail++; $display("FAIL st_mem_addr: got %h expected 80000010", d1_rec.mem_addr); end
    n_checks++; if (d1_rec.mem_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_mem_data: got %h expected deadbeef", d1_rec.mem_data); end
    n_checks++; if (d1_rec.rd_addr !== 5'd0) begin n_fail++; $display("FAIL st_rd_addr: got %0d expected 0", d1_rec.rd_addr); end
    n_checks++; if (d1_rec.seq !== 32'd2) begin n_fail++; $display("FAIL st_seq: got %0d expected 2", d1_rec.seq); end
    d1_ready = 1'b1;
    tick();
    d1_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    d1_update = 1'b1; d1_instr = 32'h00100093; d1_reg_addr = 5'd1;
    tick();
    n_checks++; if (d1_count !== 3'd1) begin n_fail++; $display("FAIL b2b_prime_count: got %0d expected 1", d1_count); end
    d1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d1_pc = 32'h80000000 + 32'(4*(i+1));
      n_checks++; if (d1_rec.seq !== 32'(i)) begin n_fail++; $display("FAIL b2b_seq[%0d]: got %0d expected %0d", i, d1_rec.seq, i); end
      tick();
      n_checks++; if (d1_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, d1_count); end
    end
    d1_update = 1'b0;
    tick();
    d1_ready = 1'b0;
    n_checks++; if (d1_count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 0", d1_count); end
  endtask

  task automatic test_stall_order();
    w_ready = 1'b0;
    drive_group(0);
    tick();
    n_checks++; if (d2_count !== 3'd2) begin n_fail++; $display("FAIL pair_count1: got %0d expected 2", d2_count); end
    n_checks++; if (d2_stall !== 1'b0) begin n_fail++; $display("FAIL pair_stall1: got %b expected 0", d2_stall); end
    drive_group(1);
    tick();
    w_update = 2'b00;
    n_checks++; if (d2_count !== 3'd4) begin n_fail++; $display("FAIL pair_count2: got %0d expected 4", d2_count); end
    n_checks++; if (d2_stall !== 1'b1) begin n_fail++; $display("FAIL pair_stall2: got %b expected 1", d2_stall); end
    n_checks++; if (d3_stall !== 1'b0) begin n_fail++; $display("FAIL drop_mode_stall: got %b expected 0", d3_stall); end
    n_checks++; if (d2_rec.seq !== 32'd0) begin n_fail++; $display("FAIL pair_head_seq: got %0d expected 0", d2_rec.seq); end
    n_checks++; if (d2_rec.pc !== 32'h1000) begin n_fail++; $display("FAIL pair_head_pc: got %h expected 1000", d2_rec.pc); end
  endtask

  task automatic test_drop();
    drive_group(2);
    tick();
    w_update = 2'b00;
    n_checks++; if (d3_drop !== 32'd2) begin n_fail++; $display("FAIL drop_cnt1: got %0d expected 2", d3_drop); end
    n_checks++; if (d3_seq !== 32'd6) begin n_fail++; $display("FAIL drop_seq1: got %0d expected 6", d3_seq); end
    n_checks++; if (d3_count !== 3'd4) begin n_fail++; $display("FAIL drop_count1: got %0d expected 4", d3_count); end
    n_checks++; if (d2_drop !== 32'd2) begin n_fail++; $display("FAIL stall_mode_drop: got %0d expected 2", d2_drop); end
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    n_checks++; if (d3_count !== 3'd3) begin n_fail++; $display("FAIL drop_pop_count: got %0d expected 3", d3_count); end
    drive_group(3);
    tick();
    w_update = 2'b00;
    n_checks++; if (d3_drop !== 32'd4) begin n_fail++; $display("FAIL drop_cnt2: got %0d expected 4", d3_drop); end
    n_checks++; if (d3_count !== 3'd3) begin n_fail++; $display("FAIL drop_count2: got %0d expected 3", d3_count); end
    n_checks++; if (d3_seq !== 32'd8) begin n_fail++; $display("FAIL drop_seq2: got %0d expected 8", d3_seq); end
  endtask

  task automatic test_drain();
    w_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_checks++; if (d3_rec.seq !== 32'(i)) begin n_fail++; $display("FAIL drain_seq[%0d]: got %0d expected %0d", i, d3_rec.seq, i); end
      n_checks++; if (d3_rec.pc !== 32'h1000 + 32'(4*i)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, d3_rec.pc, 32'h1000 + 32'(4*i)); end
      n_checks++; if (d2_rec.seq !== 32'(i)) begin n_fail++; $display("FAIL drain2_seq[%0d]: got %0d expected %0d", i, d2_rec.seq, i); end
      tick();
    end
    w_ready = 1'b0;
    n_checks++; if (d3_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", d3_valid); end
    n_checks++; if (d2_count !== 3'd0) begin n_fail++; $display("FAIL drain2_count: got %0d expected 0", d2_count); end
  endtask

  task automatic test_mid_reset();
    d1_update = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    d1_update = 1'b0;
    n_checks++; if (d1_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 3", d1_count); end
    n_checks++; if (d1_stall !== 1'b0) begin n_fail++; $display("FAIL mid_pre_stall: got %b expected 0", d1_stall); end
    rst = 1'b1; d1_update = 1'b1; d1_ready = 1'b1;
    tick();
    rst = 1'b0; d1_update = 1'b0; d1_ready = 1'b0;
    n_checks++; if (d1_count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", d1_count); end
    n_checks++; if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", d1_valid); end
    n_checks++; if (d1_seq !== 32'd0) begin n_fail++; $display("FAIL mid_seq: got %0d expected 0", d1_seq); end
    n_checks++; if (d3_drop !== 32'd0) begin n_fail++; $display("FAIL mid_drop: got %0d expected 0", d3_drop); end
  endtask

  initial begin
    rst = 1'b1;
    d1_update = '0; d1_mem_wrt = '0; d1_pc = '0; d1_instr = '0; d1_reg_data = '0;
    d1_mem_addr = '0; d1_mem_data = '0; d1_reg_addr = '0; d1_ready = 1'b0;
    w_update = '0; w_mem_wrt = '0; w_pc = '0; w_instr = '0; w_reg_data = '0;
    w_mem_addr = '0; w_mem_data = '0; w_reg_addr = '0; w_ready = 1'b0;
    #1;
    do_reset();
    test_reset();
    test_single();
    test_record_build();
    test_back_to_back();
    test_stall_order();
    test_drop();
    test_drain();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
